// File: rtl/ksa.sv
// rtl/ksa.sv - 32-bit Kogge-Stone parallel-prefix adder with registered sum and carry out
module ksa (
    output logic [31:0] s,
    output logic        cout,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    input  logic        clk,
    input  logic        rst_n
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] grp_g;
    logic [31:0] grp_p;
    logic [31:0] lvl_g;
    logic [31:0] lvl_p;
    logic [31:0] nxt_g;
    logic [31:0] nxt_p;
    logic [31:0] carry;
    logic [31:0] sum;
    logic        carry_out;

    assign g = a & b;
    assign p = a ^ b;

    // Full Kogge-Stone: every bit combines at every level, spans 1, 2, 4, 8, 16.
    always_comb begin
        lvl_g    = g;
        lvl_p    = p;
        lvl_g[0] = g[0] | (p[0] & cin);
        nxt_g    = '0;
        nxt_p    = '0;
        for (int k = 0; k < 5; k++) begin
            nxt_g = lvl_g;
            nxt_p = lvl_p;
            for (int i = 0; i < 32; i++) begin
                if (i >= (1 << k)) begin
                    nxt_g[i] = lvl_g[i] | (lvl_p[i] & lvl_g[i - (1 << k)]);
                    nxt_p[i] = lvl_p[i] & lvl_p[i - (1 << k)];
                end
            end
            lvl_g = nxt_g;
            lvl_p = nxt_p;
        end
        grp_g = lvl_g;
        grp_p = lvl_p;
    end

    // c_0 is the carry-in; c_{i+1} is the group generate over bits [i:0].
    assign carry     = {grp_g[30:0], cin};
    assign sum       = p ^ carry;
    assign carry_out = grp_g[31];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= sum;
            cout <= carry_out;
        end
    end

endmodule

// File: tb/tb_ksa.sv
// tb/tb_ksa.sv - self-checking bench for ksa against a 33-bit behavioural sum
module tb_ksa;

    logic [31:0] s;
    logic        cout;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        clk;
    logic        rst_n;

    int          checks;
    int          errors;
    logic [32:0] prev;
    logic [32:0] exp_val;
    bit          have_prev;

    ksa dut (
        .s     (s),
        .cout  (cout),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one vector; outputs must hold the previous result until the next edge.
    task automatic step(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tc, input logic tr);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        rst_n = tr;
        #1;
        if (have_prev) check({tag, "_hold"}, {cout, s}, prev);
        exp_val = tr ? ({1'b0, ta} + {1'b0, tb_v} + {32'd0, tc}) : 33'd0;
        @(posedge clk);
        #1;
        check(tag, {cout, s}, exp_val);
        prev      = exp_val;
        have_prev = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        have_prev = 1'b0;
        prev      = '0;
        exp_val   = '0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        rst_n     = 1'b0;

        step("rst0", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        step("rst1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        check("rst_val", {cout, s}, 33'd0);
        step("rst_release", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        check("release_val", {cout, s}, {1'b1, 32'd0});

        step("add_1_2", 32'd1, 32'd2, 1'b0, 1'b1);
        check("add_1_2_val", {cout, s}, 33'd3);
        step("add_100_2", 32'd100, 32'd2, 1'b0, 1'b1);
        check("add_100_2_val", {cout, s}, 33'd102);
        step("add_100_200", 32'd100, 32'd200, 1'b0, 1'b1);
        check("add_100_200_val", {cout, s}, 33'd300);

        step("ripple", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
        check("ripple_val", {cout, s}, {1'b1, 32'd0});
        step("alt_c0", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1);
        check("alt_c0_val", {cout, s}, {1'b0, 32'hFFFF_FFFF});
        step("alt_c1", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1);
        check("alt_c1_val", {cout, s}, {1'b1, 32'd0});

        step("msb_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        check("msb_ovf_val", {cout, s}, {1'b1, 32'd0});
        step("mid_rst", 32'd5, 32'd5, 1'b0, 1'b0);
        check("mid_rst_val", {cout, s}, 33'd0);
        step("post_rst", 32'd5, 32'd5, 1'b0, 1'b1);
        check("post_rst_val", {cout, s}, 33'd10);

        for (int n = 0; n < 10000; n++) begin
            step("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
